ikbd_port_mux: RTL and testbench
================================

IKBD_PORT_MUX -- requirements
Module: ikbd_port_mux

Interface
REQ-001 SHALL have parameter ROWS, default 15, number of keyboard matrix rows (1..16).
REQ-002 SHALL have parameter COLS, default 8, matrix column width (1..8).
REQ-003 SHALL have parameter DEB_CYC, default 8, joystick debounce stability cycles (1..255).
REQ-004 SHALL have parameter HOLD_CYC, default 1024, minimum cycles between mouse/joystick source switches (1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port res  input  1  synchronous, active-high reset.
REQ-007 SHALL have port matrix  input  ROWS*COLS  packed key matrix; row r is bits [r*COLS +: COLS]; active low.
REQ-008 SHALL have port row_sel_n  input  ROWS  row strobes from the 6301 port; active low.
REQ-009 SHALL have port matrix_out  output  COLS  registered AND of the selected rows.
REQ-010 SHALL have port mouse_atari  input  6  mouse quadrature/buttons {R,L,XB,XA,YB,YA}.
REQ-011 SHALL have port joystick0  input  6  mouse-shared joystick {F2,F1,R,L,D,U}, active high.
REQ-012 SHALL have port joystick1  input  5  second joystick {F,R,L,D,U}, active high.
REQ-013 SHALL have port port_oe_n  input  1  74ls244 enable; high forces pi4 to 8'hFF.
REQ-014 SHALL have port pi4  output  8  registered {~joy1[3:0], ~src[3:0]}.
REQ-015 SHALL have port fire_n  output  2  registered {~(src[5]|joy1[4]), ~src[4]}.
REQ-016 SHALL have port mouse_active  output  1  current source: 1 mouse, 0 joystick0.

Function
REQ-017 SHALL compute matrix_out one cycle after inputs as the bitwise AND over rows r with row_sel_n[r]=0 of that row; 8'hFF (COLS ones) when no row selected.
REQ-018 SHALL debounce every bit of joystick0 and joystick1 independently: the debounced bit takes the raw value only after the raw value has differed from it for DEB_CYC consecutive cycles; any return to the debounced value clears that bit's counter.
REQ-019 SHALL not debounce mouse_atari (quadrature rate must be preserved).
REQ-020 SHALL run a 2-state source FSM, MOUSE and JOY, with a hold counter saturating at HOLD_CYC.
REQ-021 SHALL flag mouse activity when mouse_atari differs from its previous-cycle copy, and joystick activity when debounced joystick0 differs from its previous-cycle copy.
REQ-022 SHALL, in JOY, go to MOUSE on mouse activity when hold counter = HOLD_CYC; in MOUSE go to JOY on joystick activity when hold counter = HOLD_CYC.
REQ-023 SHALL give mouse activity priority when both activities occur in the same cycle (stay in/enter MOUSE).
REQ-024 SHALL clear the hold counter to 0 on every transition and increment it otherwise until saturation.
REQ-025 SHALL drop activity that occurs while the hold counter is below HOLD_CYC (no queued switch).
REQ-026 SHALL select src = mouse_atari in MOUSE, debounced joystick0 in JOY; mouse_active reflects the FSM state in the same cycle src changes.
REQ-027 SHALL register pi4 and fire_n so they lag their inputs by exactly one cycle (plus debounce where applicable); port_oe_n=1 forces pi4=8'hFF on the next cycle.

Reset
REQ-028 SHALL, while res=1, set state MOUSE, hold counter HOLD_CYC (first switch immediate), debounce counters 0, debounced joysticks 0, previous-copy registers to current inputs.
REQ-029 SHALL drive during/after reset: matrix_out all ones, pi4 8'hFF, fire_n 2'b11, mouse_active 1.
REQ-030 SHALL abandon any in-progress debounce count when res asserts mid-count.

Structure
REQ-031 SHALL place source-state enum (SRC_MOUSE, SRC_JOY) and joystick bit-index constants in shared package ikbd_pkg.
REQ-032 SHALL implement debounce in one parametrised sub-module ikbd_debounce (width, DEB_CYC), instantiated once per joystick.

Verification
REQ-033 SHALL test: row_sel_n=15'h7FFE with row0=8'hFE, row1=8'hFD, then row_sel_n=15'h7FFC -> matrix_out 8'hFE then 8'hFC, each one cycle after change.
REQ-034 SHALL test: joystick1 U bit pulses high for DEB_CYC-1 cycles -> pi4[4] stays 1; held DEB_CYC cycles -> pi4[4]=0 exactly DEB_CYC+1 cycles after rise.
REQ-035 SHALL test: after reset, debounced joystick0 change -> mouse_active=0; mouse change 10 cycles later (HOLD_CYC=1024) -> stays 0; mouse change at cycle 1024 after switch -> mouse_active=1.
REQ-036 SHALL test: simultaneous mouse and joystick0 activity with hold saturated in JOY -> mouse_active=1.
REQ-037 SHALL test: mouse_atari[5]=0, joystick1[4]=1 -> fire_n=2'b01; port_oe_n=1 -> pi4=8'hFF next cycle.
REQ-038 SHALL test: res asserted mid-debounce and mid-hold -> all outputs at reset values next cycle, mouse_active=1.

Source files
------------

// File: rtl/ikbd_pkg.sv
// Shared definitions for the IKBD input port multiplexer: source-select states,
// joystick bit positions and port widths.
package ikbd_pkg;

  typedef enum logic {
    SRC_JOY   = 1'b0,
    SRC_MOUSE = 1'b1
  } src_state_e;

  // Joystick bit layout: {F2,F1,R,L,D,U} for joystick0, {F,R,L,D,U} for joystick1
  localparam int JOY_DIR_HI = 3;
  localparam int JOY_F1     = 4;
  localparam int JOY_F2     = 5;
  localparam int JOY1_FIRE  = 4;

  localparam int MOUSE_W = 6;
  localparam int JOY0_W  = 6;
  localparam int JOY1_W  = 5;

endpackage

// File: rtl/ikbd_debounce.sv
// Per-bit debouncer: the output follows the raw input only after the raw value
// has disagreed with it for DEB_CYC consecutive cycles.
module ikbd_debounce #(
  parameter int WIDTH   = 6,
  parameter int DEB_CYC = 8
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic [WIDTH-1:0] deb_q;
  logic [CW-1:0]    cnt_q [WIDTH];

  // Any cycle where raw agrees with the debounced value restarts that bit's count
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (raw_i[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == LAST) begin
          deb_q[i] <= raw_i[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/ikbd_port_mux.sv
// IKBD input port multiplexer: keyboard matrix scan, debounced joysticks and
// a hold-limited mouse/joystick0 source switch feeding the 6301 port.
module ikbd_port_mux
  import ikbd_pkg::*;
#(
  parameter int ROWS     = 15,
  parameter int COLS     = 8,
  parameter int DEB_CYC  = 8,
  parameter int HOLD_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [ROWS*COLS-1:0]   matrix,
  input  logic [ROWS-1:0]        row_sel_n,
  output logic [COLS-1:0]        matrix_out,
  input  logic [MOUSE_W-1:0]     mouse_atari,
  input  logic [JOY0_W-1:0]      joystick0,
  input  logic [JOY1_W-1:0]      joystick1,
  input  logic                   port_oe_n,
  output logic [7:0]             pi4,
  output logic [1:0]             fire_n,
  output logic                   mouse_active
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  logic [COLS-1:0]    matrixAnd_d;
  logic [COLS-1:0]    matrixOut_q;
  logic [JOY0_W-1:0]  joy0Deb;
  logic [JOY1_W-1:0]  joy1Deb;
  src_state_e         state_q;
  logic [HW-1:0]      hold_q;
  logic [MOUSE_W-1:0] mousePrev_q;
  logic [JOY0_W-1:0]  joyPrev_q;
  logic               mouseActive_q;
  logic               mouseAct;
  logic               joyAct;
  logic               holdFull;
  logic [5:0]         src;
  logic [7:0]         pi4_q;
  logic [1:0]         fire_q;

  // Keys and strobes are active low, so a pressed key in any strobed row pulls its column low
  always_comb begin
    matrixAnd_d = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel_n[r]) matrixAnd_d = matrixAnd_d & matrix[r*COLS +: COLS];
    end
  end

  always_ff @(posedge clk) begin
    if (res) matrixOut_q <= '1;
    else     matrixOut_q <= matrixAnd_d;
  end

  ikbd_debounce #(.WIDTH(JOY0_W), .DEB_CYC(DEB_CYC)) u_deb_joy0 (
    .clk_i (clk),
    .res_i (res),
    .raw_i (joystick0),
    .deb_o (joy0Deb)
  );

  ikbd_debounce #(.WIDTH(JOY1_W), .DEB_CYC(DEB_CYC)) u_deb_joy1 (
    .clk_i (clk),
    .res_i (res),
    .raw_i (joystick1),
    .deb_o (joy1Deb)
  );

  assign mouseAct = (mouse_atari != mousePrev_q);
  assign joyAct   = (joy0Deb != joyPrev_q);
  assign holdFull = (hold_q == HOLD_MAX);

  // Activity seen before the hold expires is simply dropped; mouse wins ties
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= SRC_MOUSE;
      hold_q        <= HOLD_MAX;
      mousePrev_q   <= mouse_atari;
      joyPrev_q     <= '0;
      mouseActive_q <= 1'b1;
    end else begin
      mousePrev_q <= mouse_atari;
      joyPrev_q   <= joy0Deb;
      case (state_q)
        SRC_JOY: begin
          if (mouseAct && holdFull) begin
            state_q       <= SRC_MOUSE;
            hold_q        <= '0;
            mouseActive_q <= 1'b1;
          end else if (!holdFull) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        SRC_MOUSE: begin
          if (joyAct && !mouseAct && holdFull) begin
            state_q       <= SRC_JOY;
            hold_q        <= '0;
            mouseActive_q <= 1'b0;
          end else if (!holdFull) begin
            hold_q <= hold_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign src = (state_q == SRC_MOUSE) ? mouse_atari : joy0Deb;

  always_ff @(posedge clk) begin
    if (res) begin
      pi4_q  <= 8'hFF;
      fire_q <= 2'b11;
    end else begin
      pi4_q  <= port_oe_n ? 8'hFF : {~joy1Deb[JOY_DIR_HI:0], ~src[JOY_DIR_HI:0]};
      fire_q <= {~(src[JOY_F2] | joy1Deb[JOY1_FIRE]), ~src[JOY_F1]};
    end
  end

  assign matrix_out   = matrixOut_q;
  assign pi4          = pi4_q;
  assign fire_n       = fire_q;
  assign mouse_active = mouseActive_q;

endmodule

// File: tb/tb_ikbd_port_mux.sv
// Scoreboard bench for ikbd_port_mux: a behavioural model predicts each cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_ikbd_port_mux;

  localparam int ROWS     = 15;
  localparam int COLS     = 8;
  localparam int DEB_CYC  = 8;
  localparam int HOLD_CYC = 1024;

  logic                 clk;
  logic                 res;
  logic [ROWS*COLS-1:0] matrix;
  logic [ROWS-1:0]      row_sel_n;
  logic [COLS-1:0]      matrix_out;
  logic [5:0]           mouse_atari;
  logic [5:0]           joystick0;
  logic [4:0]           joystick1;
  logic                 port_oe_n;
  logic [7:0]           pi4;
  logic [1:0]           fire_n;
  logic                 mouse_active;

  typedef struct {
    logic [COLS-1:0] mo;
    logic [7:0]      pi4;
    logic [1:0]      fire;
    logic            ma;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [5:0] mDeb0;
  logic [4:0] mDeb1;
  int         mRun0[6];
  int         mRun1[5];
  logic [5:0] mMousePrev;
  logic [5:0] mJoyPrev;
  logic       mInMouse;
  int         mSince;

  ikbd_port_mux #(
    .ROWS(ROWS), .COLS(COLS), .DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk          (clk),
    .res          (res),
    .matrix       (matrix),
    .row_sel_n    (row_sel_n),
    .matrix_out   (matrix_out),
    .mouse_atari  (mouse_atari),
    .joystick0    (joystick0),
    .joystick1    (joystick1),
    .port_oe_n    (port_oe_n),
    .pi4          (pi4),
    .fire_n       (fire_n),
    .mouse_active (mouse_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the current inputs, then clock it
  task automatic applyStimulus();
    exp_t       e;
    logic [5:0] src;
    logic       mouseMoved;
    logic       joyMoved;
    if (res) begin
      e.mo = '1; e.pi4 = 8'hFF; e.fire = 2'b11; e.ma = 1'b1;
      mDeb0 = '0; mDeb1 = '0;
      for (int b = 0; b < 6; b++) mRun0[b] = 0;
      for (int b = 0; b < 5; b++) mRun1[b] = 0;
      mMousePrev = mouse_atari; mJoyPrev = '0;
      mInMouse = 1'b1; mSince = HOLD_CYC;
    end else begin
      e.mo = '1;
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++)
          if (!row_sel_n[r] && !matrix[r*COLS + c]) e.mo[c] = 1'b0;
      src    = mInMouse ? mouse_atari : mDeb0;
      e.pi4  = port_oe_n ? 8'hFF : ~{mDeb1[3:0], src[3:0]};
      e.fire = {~(src[5] | mDeb1[4]), ~src[4]};
      mouseMoved = (mouse_atari != mMousePrev);
      joyMoved   = (mDeb0 != mJoyPrev);
      if (mSince >= HOLD_CYC && mouseMoved && !mInMouse) begin
        mInMouse = 1'b1; mSince = 0;
      end else if (mSince >= HOLD_CYC && joyMoved && !mouseMoved && mInMouse) begin
        mInMouse = 1'b0; mSince = 0;
      end else if (mSince < HOLD_CYC) begin
        mSince++;
      end
      e.ma = mInMouse;
      mMousePrev = mouse_atari;
      mJoyPrev   = mDeb0;
      for (int b = 0; b < 6; b++) begin
        if (joystick0[b] == mDeb0[b]) mRun0[b] = 0;
        else if (++mRun0[b] == DEB_CYC) begin mDeb0[b] = joystick0[b]; mRun0[b] = 0; end
      end
      for (int b = 0; b < 5; b++) begin
        if (joystick1[b] == mDeb1[b]) mRun1[b] = 0;
        else if (++mRun1[b] == DEB_CYC) begin mDeb1[b] = joystick1[b]; mRun1[b] = 0; end
      end
    end
    expQ.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Monitor: every negedge compares the oldest prediction with the registered outputs
  always @(negedge clk) begin : monitor
    exp_t m;
    if (expQ.size() != 0) begin
      m = expQ.pop_front();
      checkOutput("sb_matrix_out", matrix_out, m.mo);
      checkOutput("sb_pi4", pi4, m.pi4);
      checkOutput("sb_fire_n", {6'b0, fire_n}, {6'b0, m.fire});
      checkOutput("sb_mouse_active", {7'b0, mouse_active}, {7'b0, m.ma});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    res = 1'b1; matrix = '1; row_sel_n = '1; mouse_atari = '0;
    joystick0 = '0; joystick1 = '0; port_oe_n = 1'b0;

    idle(3);
    checkOutput("reset_matrix_out", matrix_out, 8'hFF);
    checkOutput("reset_pi4", pi4, 8'hFF);
    checkOutput("reset_fire_n", {6'b0, fire_n}, 8'h03);
    checkOutput("reset_mouse_active", {7'b0, mouse_active}, 8'h01);
    res = 1'b0;

    $display("[TB] matrix row select");
    matrix[7:0] = 8'hFE; matrix[15:8] = 8'hFD;
    row_sel_n = 15'h7FFE;
    applyStimulus();
    checkOutput("matrix_row0", matrix_out, 8'hFE);
    row_sel_n = 15'h7FFC;
    applyStimulus();
    checkOutput("matrix_row01", matrix_out, 8'hFC);

    $display("[TB] joystick1 debounce");
    joystick1[0] = 1'b1;
    idle(DEB_CYC - 1);
    joystick1[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus();
      checkOutput("joy1_glitch", {7'b0, pi4[4]}, 8'h01);
    end
    joystick1[0] = 1'b1;
    for (int k = 1; k <= DEB_CYC + 2; k++) begin
      applyStimulus();
      checkOutput("joy1_u_timing", {7'b0, pi4[4]}, (k >= DEB_CYC + 1) ? 8'h00 : 8'h01);
    end

    $display("[TB] fire and output enable");
    joystick1[4] = 1'b1;
    idle(DEB_CYC + 1);
    checkOutput("fire_n_joy1", {6'b0, fire_n}, 8'h01);
    port_oe_n = 1'b1;
    applyStimulus();
    checkOutput("pi4_oe_off", pi4, 8'hFF);
    port_oe_n = 1'b0;
    joystick1 = '0;

    $display("[TB] source switching hold");
    joystick0[0] = 1'b1;
    idle(DEB_CYC);
    checkOutput("switch_not_yet", {7'b0, mouse_active}, 8'h01);
    applyStimulus();
    checkOutput("switch_to_joy", {7'b0, mouse_active}, 8'h00);
    idle(9);
    mouse_atari[0] = ~mouse_atari[0];
    applyStimulus();
    checkOutput("hold_drop_early", {7'b0, mouse_active}, 8'h00);
    idle(HOLD_CYC - 11);
    mouse_atari[0] = ~mouse_atari[0];
    applyStimulus();
    checkOutput("hold_drop_1023", {7'b0, mouse_active}, 8'h00);
    mouse_atari[0] = ~mouse_atari[0];
    applyStimulus();
    checkOutput("hold_switch_mouse", {7'b0, mouse_active}, 8'h01);

    $display("[TB] simultaneous activity");
    idle(HOLD_CYC + 6);
    joystick0[1] = 1'b1;
    idle(DEB_CYC + 1);
    checkOutput("enter_joy", {7'b0, mouse_active}, 8'h00);
    idle(HOLD_CYC + 6);
    joystick0[2] = 1'b1;
    idle(DEB_CYC);
    mouse_atari[1] = ~mouse_atari[1];
    applyStimulus();
    checkOutput("tie_in_joy", {7'b0, mouse_active}, 8'h01);
    idle(HOLD_CYC + 6);
    joystick0[3] = 1'b1;
    idle(DEB_CYC);
    mouse_atari[2] = ~mouse_atari[2];
    applyStimulus();
    checkOutput("tie_in_mouse", {7'b0, mouse_active}, 8'h01);
    applyStimulus();
    checkOutput("tie_in_mouse_after", {7'b0, mouse_active}, 8'h01);

    $display("[TB] reset mid-debounce and mid-hold");
    joystick0[4] = 1'b1;
    idle(DEB_CYC + 1);
    checkOutput("pre_reset_joy", {7'b0, mouse_active}, 8'h00);
    joystick0[5] = 1'b1;
    idle(3);
    res = 1'b1;
    applyStimulus();
    checkOutput("midreset_matrix_out", matrix_out, 8'hFF);
    checkOutput("midreset_pi4", pi4, 8'hFF);
    checkOutput("midreset_fire_n", {6'b0, fire_n}, 8'h03);
    checkOutput("midreset_mouse_active", {7'b0, mouse_active}, 8'h01);
    res = 1'b0;
    idle(DEB_CYC);
    checkOutput("post_reset_full_debounce", {7'b0, mouse_active}, 8'h01);
    applyStimulus();
    checkOutput("post_reset_switch", {7'b0, mouse_active}, 8'h00);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) mouse_atari = 6'($urandom);
      if ($urandom_range(0, 29) == 0) joystick0[$urandom_range(0, 5)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) joystick1[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) matrix = {$urandom, $urandom, $urandom, $urandom};
      row_sel_n = ROWS'($urandom);
      port_oe_n = ($urandom_range(0, 15) == 0);
      res       = ($urandom_range(0, 999) == 0);
      applyStimulus();
    end
    res = 1'b0;
    applyStimulus();

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
